// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives a req/gnt/rvalid data bus for loads and
// stores, formats write lanes, and sign/zero-extends returned load data.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] operand2_i,
  input  logic [4:0]  stalled,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        buserr_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_err_i
);

  // state | meaning
  // IDLE  | pass-through, or issue an aligned memory op
  // REQ   | request presented, waiting for gnt
  // WAIT  | granted, waiting for rvalid or timeout
  // DONE  | result presented until EX/MEM releases the instruction

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     ld_data_q;
  logic [1:0]      off_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;

  logic            is_load, is_store, is_byte, is_half, is_word;
  logic            mem_op, misaligned, timeout_hit;
  logic [31:0]     ld_ext;
  logic            unused_stall;

  assign unused_stall = ^{stalled[4], stalled[2:0]};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    unique case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
      EXE_LH_OP, EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
      EXE_LW_OP:             begin is_load  = 1'b1; is_word = 1'b1; end
      EXE_SB_OP:             begin is_store = 1'b1; is_byte = 1'b1; end
      EXE_SH_OP:             begin is_store = 1'b1; is_half = 1'b1; end
      EXE_SW_OP:             begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign mem_op     = is_load | is_store;
  assign misaligned = (is_half & mem_addr_i[0]) | (is_word & (|mem_addr_i[1:0]));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Bus fields come straight from the held EX/MEM inputs, so they stay stable in REQ.
  always_comb begin
    dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
    dbus_we_o    = is_store;
    dbus_be_o    = 4'b0000;
    dbus_wdata_o = operand2_i;
    if (is_byte) begin
      dbus_be_o    = 4'b0001 << mem_addr_i[1:0];
      dbus_wdata_o = {4{operand2_i[7:0]}};
    end else if (is_half) begin
      dbus_be_o    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      dbus_wdata_o = {2{operand2_i[15:0]}};
    end else if (is_word) begin
      dbus_be_o    = 4'b1111;
    end
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    ld_ext = ld_data_q;
    case (off_q)
      2'd0:    b = ld_data_q[7:0];
      2'd1:    b = ld_data_q[15:8];
      2'd2:    b = ld_data_q[23:16];
      default: b = ld_data_q[31:24];
    endcase
    h = off_q[1] ? ld_data_q[31:16] : ld_data_q[15:0];
    case (aluop_i)
      EXE_LB_OP:  ld_ext = {{24{b[7]}}, b};
      EXE_LBU_OP: ld_ext = {24'd0, b};
      EXE_LH_OP:  ld_ext = {{16{h[15]}}, h};
      EXE_LHU_OP: ld_ext = {16'd0, h};
      default:    ld_ext = ld_data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ld_data_q <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (mem_op && !misaligned) begin
            off_q <= mem_addr_i[1:0];
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (dbus_rvalid_i) begin
            ld_data_q <= dbus_rdata_i;
            err_q     <= dbus_err_i;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    dbus_req_o = 1'b0;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    buserr_o   = 1'b0;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          wreg_o = 1'b0;
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            dbus_req_o = 1'b1;
            stallreq_o = 1'b1;
            state_d    = dbus_gnt_i ? WAIT : REQ;
          end
        end
      end
      REQ: begin
        dbus_req_o = 1'b1;
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        if (dbus_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        if (dbus_rvalid_i || timeout_hit) state_d = DONE;
      end
      DONE: begin
        buserr_o = err_q;
        if (is_load && !err_q) begin
          wdata_o = ld_ext;
        end else begin
          wreg_o = 1'b0;
        end
        // Held inputs still describe the finished access; reissuing would repeat it.
        if (!stalled[3]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Scenario bench for mem_access: scripted bus responder plus an expected-result
// queue that is filled at issue time and drained when each access completes.
module tb_mem_access;

  localparam int TO = 4;
  localparam logic [7:0] ADD = 8'b0010_0000;
  localparam logic [7:0] LB  = 8'b1110_0000, LH  = 8'b1110_0001, LW = 8'b1110_0011;
  localparam logic [7:0] LBU = 8'b1110_0100, LHU = 8'b1110_0101;
  localparam logic [7:0] SB  = 8'b1110_1000, SH  = 8'b1110_1001, SW = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i, wd_o, stalled;
  logic        wreg_i, wreg_o, stallreq_o, misalign_o, buserr_o;
  logic [31:0] wdata_i, wdata_o, mem_addr_i, operand2_i;
  logic [7:0]  aluop_i;
  logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_be_o;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .operand2_i(operand2_i),
    .stalled(stalled), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .misalign_o(misalign_o), .buserr_o(buserr_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wreg;
    logic [31:0] wdata;
    logic        buserr;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int fails = 0;

  function automatic logic is_ld(input logic [7:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * addr[1:0]);
    case (op)
      LB:      return {{24{sh[7]}}, sh[7:0]};
      LBU:     return {24'd0, sh[7:0]};
      LH:      return {{16{sh[15]}}, sh[15:0]};
      LHU:     return {16'd0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [7:0] op, input logic [31:0] addr);
    if (op == LB || op == LBU || op == SB) return 4'b0001 << addr[1:0];
    if (op == LH || op == LHU || op == SH) return addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] d);
    if (op == SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (op == SH) return {d[15:0], d[15:0]};
    return d;
  endfunction

  task automatic set_nop();
    aluop_i = ADD; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0;
    mem_addr_i = 32'd0; operand2_i = 32'd0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = 32'd0;
  endtask

  // Drives one access; gnt after gnt_dly cycles of req, rvalid the cycle after gnt
  // unless respond=0. Holds DONE for 'hold' cycles with stalled[3]=1.
  task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] op2,
                        input logic [31:0] rdata, input logic err, input int gnt_dly,
                        input bit respond, input int hold, output int stalls);
    exp_t e, got;
    bit   done;
    e.wreg   = is_ld(op) && !err && respond;
    e.wdata  = e.wreg ? model_load(op, addr, rdata) : 32'hDEAD_0000;
    e.buserr = err || !respond;
    sb.push_back(e);
    aluop_i = op; mem_addr_i = addr; operand2_i = op2;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD_0000;
    stalls = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      dbus_gnt_i    = (c == gnt_dly);
      dbus_rvalid_i = respond && (c == gnt_dly + 1);
      dbus_rdata_i  = dbus_rvalid_i ? rdata : 32'h5A5A_5A5A;
      dbus_err_i    = dbus_rvalid_i ? err : 1'b1;
      @(negedge clk);
      if (stallreq_o) begin
        stalls++;
        tests_run++;
        if (c <= gnt_dly) begin
          if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o} !==
              {1'b1, !is_ld(op), {addr[31:2], 2'b00}, model_be(op, addr)} ||
              (!is_ld(op) && dbus_wdata_o !== model_wdata(op, op2)) || wreg_o !== 1'b0) begin
            fails++;
            $display("FAIL req_fields c=%0d: req=%b we=%b addr=%h be=%b wd=%h wreg=%b, want be=%b wd=%h",
                     c, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, wreg_o,
                     model_be(op, addr), model_wdata(op, op2));
          end
        end else if (dbus_req_o !== 1'b0 || wreg_o !== 1'b0) begin
          fails++;
          $display("FAIL wait_quiet c=%0d: req=%b wreg=%b, want 0 0", c, dbus_req_o, wreg_o);
        end
      end else begin
        done = 1;
        got = sb.pop_front();
        tests_run++;
        if (wreg_o !== got.wreg || buserr_o !== got.buserr || misalign_o !== 1'b0 ||
            dbus_req_o !== 1'b0 || (got.wreg && wdata_o !== got.wdata)) begin
          fails++;
          $display("FAIL done op=%h: wreg=%b wdata=%h buserr=%b req=%b, want wreg=%b wdata=%h buserr=%b",
                   op, wreg_o, wdata_o, buserr_o, dbus_req_o, got.wreg, got.wdata, got.buserr);
        end
        stalled = 5'b01000 & {5{hold != 0}};
        for (int k = 0; k < hold; k++) begin
          @(posedge clk); #1;
          dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1111_1111;
          @(negedge clk);
          tests_run++;
          if (dbus_req_o !== 1'b0 || stallreq_o !== 1'b0 || wreg_o !== got.wreg ||
              (got.wreg && wdata_o !== got.wdata) || buserr_o !== got.buserr) begin
            fails++;
            $display("FAIL done_hold k=%0d: req=%b stall=%b wreg=%b wdata=%h, want 0 0 %b %h",
                     k, dbus_req_o, stallreq_o, wreg_o, wdata_o, got.wreg, got.wdata);
          end
        end
        stalled = 5'b00000;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      tests_run++; fails++;
      $display("FAIL access_timeout op=%h: no completion within 64 cycles", op);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    set_nop();
  endtask

  task automatic test_reset();
    rst = 1'b0; stalled = 5'd0; set_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({stallreq_o, dbus_req_o, misalign_o, buserr_o} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: stall/req/mis/err=%b, want 0000",
               {stallreq_o, dbus_req_o, misalign_o, buserr_o});
    end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_passthrough();
    aluop_i = ADD; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
    @(negedge clk);
    tests_run++;
    if ({wd_o, wreg_o, wdata_o, stallreq_o, dbus_req_o} !== {5'd5, 1'b1, 32'h1234, 2'b00}) begin
      fails++;
      $display("FAIL passthrough: wd=%0d wreg=%b wdata=%h stall=%b req=%b, want 5 1 1234 0 0",
               wd_o, wreg_o, wdata_o, stallreq_o, dbus_req_o);
    end
    @(posedge clk); #1; set_nop();
  endtask

  task automatic check_stalls(input string name, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: stall cycles=%0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_load_byte();
    int s;
    access(LB,  32'h103, 32'd0, 32'h80FF_FF00, 1'b0, 0, 1, 0, s); check_stalls("lb_latency", s, 2);
    access(LBU, 32'h103, 32'd0, 32'h80FF_FF00, 1'b0, 0, 1, 0, s); check_stalls("lbu_latency", s, 2);
  endtask

  task automatic test_store_half();
    int s;
    access(SH, 32'h202, 32'hAAAA_BEEF, 32'd0, 1'b0, 3, 1, 0, s); check_stalls("sh_latency", s, 5);
  endtask

  task automatic test_misalign();
    logic [7:0]  ops[4]   = '{LW, LH, SW, LHU};
    logic [31:0] addrs[4] = '{32'h101, 32'h201, 32'h102, 32'h103};
    for (int i = 0; i < 4; i++) begin
      aluop_i = ops[i]; mem_addr_i = addrs[i]; wreg_i = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({misalign_o, dbus_req_o, stallreq_o, wreg_o} !== 4'b1000) begin
        fails++;
        $display("FAIL misalign i=%0d: mis/req/stall/wreg=%b, want 1000", i,
                 {misalign_o, dbus_req_o, stallreq_o, wreg_o});
      end
      @(posedge clk); #1;
    end
    set_nop();
  endtask

  task automatic test_errors();
    int s;
    access(LW, 32'h500, 32'd0, 32'hCAFE_F00D, 1'b1, 0, 1, 0, s); check_stalls("err_latency", s, 2);
    access(LW, 32'h504, 32'd0, 32'd0, 1'b0, 0, 0, 0, s);          check_stalls("timeout_latency", s, 1 + TO);
  endtask

  task automatic test_done_hold();
    int s;
    stalled = 5'd0;
    access(LH, 32'h102, 32'd0, 32'hC3A5_0000, 1'b0, 1, 1, 3, s); check_stalls("hold_latency", s, 3);
  endtask

  task automatic test_back_to_back();
    int s;
    access(LW,  32'h400, 32'd0, 32'h1234_5678, 1'b0, 0, 1, 0, s);
    access(LHU, 32'h402, 32'd0, 32'h8001_7777, 1'b0, 0, 1, 0, s);
    access(LH,  32'h400, 32'd0, 32'h0000_8001, 1'b0, 2, 1, 0, s);
    access(SB,  32'h401, 32'h0000_00AB, 32'd0, 1'b0, 1, 1, 0, s);
    access(SW,  32'h408, 32'h0123_4567, 32'd0, 1'b0, 0, 1, 0, s);
    check_stalls("sw_latency", s, 2);
  endtask

  task automatic test_reset_mid_wait();
    aluop_i = LW; mem_addr_i = 32'h300; wreg_i = 1'b1; dbus_gnt_i = 1'b1;
    @(posedge clk); #1;
    dbus_gnt_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (stallreq_o !== 1'b1 || dbus_req_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_pre_wait: stall=%b req=%b, want 1 0", stallreq_o, dbus_req_o);
    end
    rst = 1'b0; set_nop();
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (stallreq_o !== 1'b0 || dbus_req_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_wait: stall=%b req=%b, want 0 0", stallreq_o, dbus_req_o);
    end
    @(posedge clk); #1; rst = 1'b1;
    wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h0BAD_BEEF;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    tests_run++;
    if ({wd_o, wreg_o, wdata_o, stallreq_o} !== {5'd9, 1'b1, 32'h0BAD_BEEF, 1'b0}) begin
      fails++;
      $display("FAIL stray_rvalid: wd=%0d wreg=%b wdata=%h stall=%b, want 9 1 0badbeef 0",
               wd_o, wreg_o, wdata_o, stallreq_o);
    end
    @(posedge clk); #1; set_nop();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_errors();
    test_done_hold();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
